scratch_pad_responder: RTL and testbench

// - Responder side of the decoder scratch-pad interface: owns the 8K x 64b scratch RAM and services
//   req_scratch_ld/st from sparse_matrix_decoder, returning ordered read data on rsp_scratch_push/q.
// - Buffers read responses against consumer back-pressure and throttles the requester via req_scratch_stall.

---
 rtl/spmv_scratch_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/scratch_pad_responder.sv | 135 +++++++++++++
 tb/tb_scratch_pad_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spmv_scratch_pkg.sv
// Shared constants and types for the decoder scratch-pad interface.
package spmv_scratch_pkg;

  localparam int unsigned SCRATCH_ADDR_WIDTH     = 13;
  localparam int unsigned SCRATCH_DATA_WIDTH     = 64;
  localparam int unsigned SCRATCH_DEPTH          = 512 * 16;
  localparam int unsigned SCRATCH_RSP_FIFO_DEPTH = 8;
  localparam int unsigned SCRATCH_STALL_SLACK    = 3;

  // Bookkeeping that travels alongside the RAM registered read output.
  typedef struct packed {
    logic vld;
    logic in_range;
  } scratch_rd_stage_t;

  // True when a word address falls inside the populated part of the RAM.
  function automatic logic scratch_addr_ok(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a write into a full FIFO is accepted
// when a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  // Accept/advance decisions; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    do_rd    = rd_en_i && (count_q != '0);
    do_wr    = wr_en_i && ((count_q != FullCnt) || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(do_wr) - CntW'(do_rd);
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == FullCnt);
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/scratch_pad_responder.sv
// Responder side of the decoder scratch-pad: owns the scratch RAM, serves loads
// and stores, returns read data in issue order and throttles the requester.
module scratch_pad_responder
  import spmv_scratch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = SCRATCH_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = SCRATCH_DATA_WIDTH,
  parameter int unsigned DEPTH          = SCRATCH_DEPTH,
  parameter int unsigned RSP_FIFO_DEPTH = SCRATCH_RSP_FIFO_DEPTH,
  parameter int unsigned STALL_SLACK    = SCRATCH_STALL_SLACK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_scratch_ld,
  input  logic                  req_scratch_st,
  input  logic [ADDR_WIDTH-1:0] req_scratch_addr,
  input  logic [DATA_WIDTH-1:0] req_scratch_d,
  output logic                  req_scratch_stall,
  output logic                  rsp_scratch_push,
  output logic [DATA_WIDTH-1:0] rsp_scratch_q,
  input  logic                  rsp_scratch_stall,
  output logic                  overflow_err
);

  localparam int unsigned     CntW     = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] FullOcc  = CntW'(RSP_FIFO_DEPTH);
  localparam logic [CntW-1:0] StallOcc = CntW'(RSP_FIFO_DEPTH - STALL_SLACK);

  // RAM and read stage
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata_q;
  scratch_rd_stage_t     rd_stage_q, rd_stage_d;
  logic                  addr_ok;
  logic                  ld_accept;

  // Response buffer
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  // Credit tracking and output stage
  logic [CntW-1:0]       occ, occ_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  stall_q, stall_d;
  logic                  overflow_q, overflow_d;

  assign addr_ok = scratch_addr_ok(32'(req_scratch_addr), DEPTH);

  // Load admission: occupancy counts buffered words plus the read in the RAM stage.
  always_comb begin
    occ        = fifo_count + CntW'(rd_stage_q.vld);
    ld_accept  = req_scratch_ld && (occ < FullOcc);
    rd_stage_d = '{vld: ld_accept, in_range: addr_ok};
  end

  // RAM with registered output; the read sees the pre-write word on a same-address ld+st.
  always_ff @(posedge clk) begin
    if (req_scratch_st && addr_ok) begin
      mem[req_scratch_addr] <= req_scratch_d;
    end
    if (ld_accept) begin
      ram_rdata_q <= mem[req_scratch_addr];
    end
  end

  // Valid flag for the RAM stage; a reset discards the read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_stage_q <= '0;
    end else begin
      rd_stage_q <= rd_stage_d;
    end
  end

  // Out-of-range reads still occupy a slot so ordering is kept, but return zero.
  assign fifo_wdata = rd_stage_q.in_range ? ram_rdata_q : '0;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (rd_stage_q.vld),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Output stage and credit next-state.
  always_comb begin
    fifo_pop   = !rsp_scratch_stall && !fifo_empty;
    occ_d      = occ + CntW'(ld_accept) - CntW'(fifo_pop);
    push_d     = fifo_pop;
    q_d        = fifo_pop ? fifo_rdata : q_q;
    // Registered from next occupancy so the flag matches the occupancy it describes.
    stall_d    = (occ_d >= StallOcc);
    overflow_d = overflow_q || (req_scratch_ld && !ld_accept);
  end

  // Output, back-pressure and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q     <= 1'b0;
      q_q        <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      push_q     <= push_d;
      q_q        <= q_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  // Credit accounting must never deliver a read into a full, non-draining buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rd_stage_q.vld && fifo_full && !fifo_pop));
    end
  end

  assign rsp_scratch_push  = push_q;
  assign rsp_scratch_q     = q_q;
  assign req_scratch_stall = stall_q;
  assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_scratch_pad_responder.sv
// Scoreboard bench: the driver pushes expected read data computed from a word-level
// memory model; a separate monitor pops and compares on every rsp_scratch_push.
module tb_scratch_pad_responder;

  localparam int AW     = 13;
  localparam int DW     = 64;
  localparam int FD     = 8;
  localparam int THRESH = 5;
  localparam int SLACK  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_scratch_ld;
  logic          req_scratch_st;
  logic [AW-1:0] req_scratch_addr;
  logic [DW-1:0] req_scratch_d;
  logic          req_scratch_stall;
  logic          rsp_scratch_push;
  logic [DW-1:0] rsp_scratch_q;
  logic          rsp_scratch_stall;
  logic          overflow_err;

  always #5 clk = ~clk;

  scratch_pad_responder dut (
    .clk               (clk),
    .rst               (rst),
    .req_scratch_ld    (req_scratch_ld),
    .req_scratch_st    (req_scratch_st),
    .req_scratch_addr  (req_scratch_addr),
    .req_scratch_d     (req_scratch_d),
    .req_scratch_stall (req_scratch_stall),
    .rsp_scratch_push  (rsp_scratch_push),
    .rsp_scratch_q     (rsp_scratch_q),
    .rsp_scratch_stall (rsp_scratch_stall),
    .overflow_err      (overflow_err)
  );

  // Reference model: word memory, outstanding-response queue and credit counters.
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q [$];
  int            accepted;
  int            popped;
  bit            exp_err;
  bit            mon_en;
  int            n_checks;
  int            n_fail;

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: samples 1ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) begin
        if (rsp_scratch_push) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_push: got q=%h, expected no response", rsp_scratch_q);
          end else begin
            check("rsp_q", rsp_scratch_q, exp_q.pop_front());
            popped++;
          end
        end
        check("req_stall", DW'(req_scratch_stall), DW'((accepted - popped) >= THRESH));
        check("overflow_err", DW'(overflow_err), DW'(exp_err));
      end
    end
  end

  // Drive one cycle of requests at the falling edge and update the model.
  task automatic cycle(input bit ld, input bit st, input int addr, input logic [DW-1:0] d,
                       input bit cs);
    int occ;
    req_scratch_ld    = ld;
    req_scratch_st    = st;
    req_scratch_addr  = AW'(addr);
    req_scratch_d     = d;
    rsp_scratch_stall = cs;
    occ = accepted - popped;
    if (ld) begin
      if (occ >= FD) begin
        exp_err = 1'b1;
      end else begin
        exp_q.push_back(model_mem[addr]);
        accepted++;
      end
    end
    if (st) model_mem[addr] = d;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(0, 0, 0, '0, 0);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses pending, expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push"}, DW'(rsp_scratch_push), '0);
    check({tag, "_q"}, rsp_scratch_q, '0);
    check({tag, "_stall"}, DW'(req_scratch_stall), '0);
    check({tag, "_overflow"}, DW'(overflow_err), '0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    req_scratch_ld = 1'b0; req_scratch_st = 1'b0; req_scratch_addr = '0;
    req_scratch_d = '0; rsp_scratch_stall = 1'b0;
    mon_en = 1'b0; accepted = 0; popped = 0; exp_err = 1'b0;
    n_checks = 0; n_fail = 0;

    // Power-on reset.
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Store then load: push two edges after the load is sampled, q held afterwards.
    cycle(0, 1, 5, 64'hDEAD_BEEF, 0);
    cycle(1, 0, 5, '0, 0);
    cycle(0, 0, 0, '0, 0);
    check("lat_push_n1", DW'(rsp_scratch_push), '0);
    cycle(0, 0, 0, '0, 0);
    check("lat_push_n2", DW'(rsp_scratch_push), DW'(1));
    check("lat_q_n2", rsp_scratch_q, 64'hDEAD_BEEF);
    cycle(0, 0, 0, '0, 0);
    check("hold_push", DW'(rsp_scratch_push), '0);
    check("hold_q", rsp_scratch_q, 64'hDEAD_BEEF);

    // Fill a small working set.
    for (int a = 0; a < 32; a++) cycle(0, 1, a, {$urandom, $urandom}, 0);

    // Same-cycle ld+st returns the old word; a later load sees the new one.
    cycle(0, 1, 7, 64'd1, 0);
    cycle(1, 1, 7, 64'd2, 0);
    cycle(1, 0, 7, '0, 0);
    drain(20);

    // Back-to-back loads 0..7.
    for (int a = 0; a < 8; a++) cycle(1, 0, a, '0, 0);
    drain(30);

    // Consumer stalled: requester honours stall after STALL_SLACK more loads.
    n = 0;
    while (!req_scratch_stall && n < 20) begin
      cycle(1, 0, 8 + n, '0, 1);
      n++;
    end
    check("loads_before_stall", DW'(n), DW'(THRESH));
    for (int i = 0; i < SLACK; i++) cycle(1, 0, 20 + i, '0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1);
    drain(30);

    // Randomised traffic with a requester that respects back-pressure.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 1) == 1) && !req_scratch_stall,
            $urandom_range(0, 2) == 0, $urandom_range(0, 31), {$urandom, $urandom},
            $urandom_range(0, 3) == 0);
    end
    drain(60);

    // Nine loads against a stalled consumer, stall ignored: one dropped, eight delivered.
    for (int i = 0; i < 9; i++) cycle(1, 0, 16 + i, '0, 1);
    check("overflow_set", DW'(overflow_err), DW'(1));
    drain(40);

    // Reset with responses pending: outputs clear at once, nothing stale afterwards.
    for (int i = 0; i < 9; i++) cycle(1, 0, i, '0, 1);
    cycle(0, 0, 0, '0, 0);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    accepted = 0; popped = 0; exp_err = 1'b0;
    rsp_scratch_stall = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0, 0);

    // RAM contents survive reset and the path still works.
    for (int a = 0; a < 4; a++) cycle(1, 0, a, '0, 0);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
